// File: rtl/phy_tx_lane_striper.sv
// Round-robin word striper with per-lane FIFOs and lane-aligned MSB-first byte serialisers.
// Build option PHY_TX_SKP_IDLE_EN: idle bytes alternate IDLE_SYM and 8'h1C instead of repeating IDLE_SYM.
module phy_tx_lane_striper #(
  parameter int         NUM_LANES      = 2,
  parameter int         BYTES_PER_WORD = 4,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] IDLE_SYM       = 8'hBC,
  localparam int        WORD_W         = 8 * BYTES_PER_WORD,
  localparam int        SEL_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    data_input,
  input  logic                 valid,
  input  logic                 active,
  output logic                 ready,
  output logic [NUM_LANES-1:0] data_out,
  output logic [NUM_LANES-1:0] valid_out,
  output logic [SEL_W-1:0]     lane_sel
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam int               IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = (BYTES_PER_WORD == 1) ? '0 : IDX_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  logic [SEL_W-1:0]     r_lane_sel;
  logic [2:0]           r_bit_cnt;
  logic                 r_first;
  logic [NUM_LANES-1:0] w_full;
  logic                 w_accept;
  logic                 w_boundary;

  // r_first makes the first edge after reset release a byte boundary for every lane.
  assign w_boundary = r_first || (r_bit_cnt == 3'd7);
  assign ready      = active && !reset && !w_full[r_lane_sel];
  assign w_accept   = valid && ready;
  assign lane_sel   = r_lane_sel;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_lane_sel <= '0;
    end else if (w_accept) begin
      r_lane_sel <= (r_lane_sel == LAST_LANE) ? '0 : r_lane_sel + 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_first   <= 1'b1;
    end else begin
      r_first   <= 1'b0;
      r_bit_cnt <= w_boundary ? 3'd0 : r_bit_cnt + 3'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_byte_idx;
    logic [7:0]        r_shift;
    logic              r_dout;
    logic              r_vout;
    logic              w_wr;
    logic              w_pop;
    logic              w_empty;
    logic [WORD_W-1:0] w_head;
    logic [7:0]        w_idle_byte;
    logic [7:0]        w_load_byte;

    assign w_empty    = (r_count == '0);
    assign w_full[gi] = (r_count == FULL_CNT);
    assign w_wr       = w_accept && (r_lane_sel == SEL_W'(gi));
    assign w_pop      = w_boundary && (r_byte_idx == '0) && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_32f) begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= data_input;
      end
    end

    always_ff @(posedge clk_32f) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_wr, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

`ifdef PHY_TX_SKP_IDLE_EN
    logic r_skp;

    // Toggles on every idle byte; a popped word restarts the idle pattern at IDLE_SYM.
    always_ff @(posedge clk_32f) begin
      if (reset) begin
        r_skp <= 1'b0;
      end else if (w_boundary && (r_byte_idx == '0)) begin
        r_skp <= w_empty ? ~r_skp : 1'b0;
      end
    end

    assign w_idle_byte = r_skp ? 8'h1C : IDLE_SYM;
`else
    assign w_idle_byte = IDLE_SYM;
`endif

    always_comb begin
      w_load_byte = w_idle_byte;
      if (r_byte_idx != '0) begin
        w_load_byte = r_word[WORD_W-1 -: 8];
      end else if (!w_empty) begin
        w_load_byte = w_head[WORD_W-1 -: 8];
      end
    end

    always_ff @(posedge clk_32f) begin
      if (reset) begin
        r_word     <= '0;
        r_byte_idx <= '0;
        r_shift    <= '0;
        r_dout     <= 1'b0;
        r_vout     <= 1'b0;
      end else if (w_boundary) begin
        r_dout  <= w_load_byte[7];
        r_shift <= {w_load_byte[6:0], 1'b0};
        if (r_byte_idx != '0) begin
          r_word     <= r_word << 8;
          r_byte_idx <= (r_byte_idx == LAST_BYTE) ? '0 : r_byte_idx + 1'b1;
        end else if (!w_empty) begin
          r_word     <= w_head << 8;
          r_byte_idx <= FIRST_IDX;
          r_vout     <= 1'b1;
        end else begin
          r_vout     <= 1'b0;
        end
      end else begin
        r_dout  <= r_shift[7];
        r_shift <= r_shift << 1;
      end
    end

    assign data_out[gi]  = r_dout;
    assign valid_out[gi] = r_vout;
  end

endmodule

// File: tb/tb_phy_tx_lane_striper.sv
// Scoreboard bench for phy_tx_lane_striper: a byte-level lane model pushes expected bytes at each
// boundary, a monitor rebuilds each serial byte and pops/compares; ready and lane_sel are checked each cycle.
module tb_phy_tx_lane_striper;

  localparam int NL    = 2;
  localparam int DEPTH = 2;
`ifdef PHY_TX_SKP_IDLE_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic          clk_32f    = 1'b0;
  logic          reset      = 1'b1;
  logic          valid      = 1'b0;
  logic          active     = 1'b0;
  logic [31:0]   data_input = '0;
  logic          ready;
  logic [NL-1:0] data_out;
  logic [NL-1:0] valid_out;
  logic [0:0]    lane_sel;

  phy_tx_lane_striper #(
    .NUM_LANES      (NL),
    .BYTES_PER_WORD (4),
    .FIFO_DEPTH     (DEPTH),
    .IDLE_SYM       (8'hBC)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_input (data_input),
    .valid      (valid),
    .active     (active),
    .ready      (ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_sel   (lane_sel)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic       v;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int          m_sel     = 0;
  int          m_phase   = 0;
  int          m_acc_cnt = 0;
  bit          m_first   = 1'b1;
  bit          m_run     = 1'b0;
  logic [31:0] m_fifo [NL][DEPTH];
  int          m_cnt  [NL];
  logic [31:0] m_word [NL];
  int          m_bidx [NL];
  bit          m_tog  [NL];
  logic [7:0]  s_byte [NL];
  int          s_ones [NL];

  bit          p_acc;
  exp_t        p_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and serial monitor, advanced once per rising edge.
  always @(posedge clk_32f) begin
    if (reset) begin
      m_sel   = 0;
      m_first = 1'b1;
      m_phase = 0;
      m_run   = 1'b0;
      exp_q.delete();
      for (int l = 0; l < NL; l++) begin
        m_cnt[l]  = 0;
        m_bidx[l] = 0;
        m_tog[l]  = 1'b0;
        s_byte[l] = '0;
        s_ones[l] = 0;
      end
      #1;
      chk("reset_data_out", 32'(data_out), 32'd0);
      chk("reset_valid_out", 32'(valid_out), 32'd0);
    end else begin
      p_acc = valid && active && (m_cnt[m_sel] < DEPTH);
      if (m_first || m_phase == 7) begin
        m_first = 1'b0;
        m_phase = 0;
        m_run   = 1'b1;
        for (int l = 0; l < NL; l++) begin
          if (m_bidx[l] != 0) begin
            p_e.v     = 1'b1;
            p_e.b     = m_word[l][(3 - m_bidx[l]) * 8 +: 8];
            m_bidx[l] = (m_bidx[l] == 3) ? 0 : m_bidx[l] + 1;
          end else if (m_cnt[l] > 0) begin
            m_word[l] = m_fifo[l][0];
            for (int i = 0; i < DEPTH - 1; i++) m_fifo[l][i] = m_fifo[l][i + 1];
            m_cnt[l]--;
            p_e.v     = 1'b1;
            p_e.b     = m_word[l][31:24];
            m_bidx[l] = 1;
            m_tog[l]  = 1'b0;
          end else begin
            p_e.v    = 1'b0;
            p_e.b    = (SKP_ON && m_tog[l]) ? 8'h1C : 8'hBC;
            m_tog[l] = !m_tog[l];
          end
          exp_q.push_back(p_e);
        end
      end else begin
        m_phase++;
      end
      if (p_acc) begin
        m_fifo[m_sel][m_cnt[m_sel]] = data_input;
        m_cnt[m_sel]++;
        m_sel = (m_sel + 1) % NL;
        m_acc_cnt++;
      end
      #1;
      if (m_run) begin
        for (int l = 0; l < NL; l++) begin
          s_byte[l] = {s_byte[l][6:0], data_out[l]};
          s_ones[l] += int'(valid_out[l]);
        end
        if (m_phase == 7) begin
          for (int l = 0; l < NL; l++) begin
            p_e = exp_q.pop_front();
            chk($sformatf("lane%0d_byte", l), 32'(s_byte[l]), 32'(p_e.b));
            chk($sformatf("lane%0d_valid_bits", l), 32'(s_ones[l]), p_e.v ? 32'd8 : 32'd0);
            s_ones[l] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk_32f) begin
    #1;
    chk("ready", 32'(ready), 32'(active && !reset && (m_cnt[m_sel] < DEPTH)));
    chk("lane_sel", 32'(lane_sel), 32'(m_sel));
  end

  task automatic send(input logic [31:0] w);
    int start;
    bit got;
    data_input = w;
    valid      = 1'b1;
    start      = m_acc_cnt;
    got        = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk_32f);
      if (m_acc_cnt != start) got = 1'b1;
    end
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    int  t0;
    bit  got;

    // Reset, then idle symbols on both lanes
    reset = 1'b1;
    repeat (3) @(negedge clk_32f);
    reset  = 1'b0;
    active = 1'b1;
    repeat (24) @(negedge clk_32f);

    // Striping: two words on consecutive cycles
    send(32'hA1B2C3D4);
    send(32'h11223344);
    valid = 1'b0;
    repeat (60) @(negedge clk_32f);

    // Backpressure: six back-to-back words into depth-2 FIFOs
    for (int i = 0; i < 6; i++) send(32'h50607080 + 32'(i) * 32'h01010101);
    valid = 1'b0;
    repeat (150) @(negedge clk_32f);

    // Link inactive: nothing accepted until active rises
    active     = 1'b0;
    valid      = 1'b1;
    data_input = 32'hDEADBEEF;
    t0         = m_acc_cnt;
    repeat (30) @(negedge clk_32f);
    chk("inactive_accepts", 32'(m_acc_cnt - t0), 32'd0);
    active = 1'b1;
    send(32'hDEADBEEF);
    valid = 1'b0;
    repeat (60) @(negedge clk_32f);

    // Reset in the middle of a word; the word must not resume
    send(32'hCAFEF00D);
    send(32'h0BADC0DE);
    valid = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_32f);
      if ((m_bidx[0] == 3 || m_bidx[1] == 3) && m_phase == 3) got = 1'b1;
    end
    chk("reset_point_timeout", 32'(got), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk_32f);
    reset = 1'b0;
    repeat (48) @(negedge clk_32f);

    // One word on a lane, then its idle pattern restarts
    send(32'h0F1E2D3C);
    valid = 1'b0;
    repeat (80) @(negedge clk_32f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
